pipe_stage_skid: RTL

Parametrised pipeline stage register that succeeds the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic payload and control vector with valid/ready flow control, a 2-entry skid buffer so `in_ready` is a registered signal, and a synchronous flush that kills in-flight entries. Every stage boundary of the five-stage core instantiates it, with widths set per boundary.

---
 rtl/pipe_stage_skid_pkg.sv | 21 ++
 rtl/pipe_stage_skid_if.sv | 28 ++
 rtl/pipe_stage_skid_slot.sv | 39 +++
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and per-boundary widths for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int unsigned IF_ID_CTRL_W  = 4;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned EX_MEM_CTRL_W = 12;
  localparam int unsigned EX_MEM_DATA_W = 64;
  localparam int unsigned MEM_WB_CTRL_W = 6;
  localparam int unsigned MEM_WB_DATA_W = 32;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle of one pipeline stage boundary.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
);
  import pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// Ctrl+data holding register; PIPE_STAGE_CLR_DATA_EN makes the sync clear also zero data.
module pipe_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clr_i) begin
      ctrl_q <= '0;
`ifdef PIPE_STAGE_CLR_DATA_EN
      data_q <= '0;
`else
      data_q <= data_q;
`endif
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, registered in_ready and sync flush.
// Build option: PIPE_STAGE_CLR_DATA_EN (flush also zeroes payload, see pipe_slot).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_skid_if.slave     bus
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire, out_valid;
  logic              main_load, skid_load, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over both handshakes; the offered entry is dropped.
    if (flush) begin
      state_d        = EMPTY;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
    end
    in_ready_d = (state_d != FULL);
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : bus.in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : bus.in_data;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (main_load),
    .clr_i  (flush),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .ctrl_o (main_ctrl),
    .data_o (main_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (skid_load),
    .clr_i  (flush),
    .ctrl_i (bus.in_ctrl),
    .data_i (bus.in_data),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.occupancy = state_q;

endmodule
